// File: rtl/llr_fg_pe_array.sv
// Two-stage array of LANES SC-polar LLR processing elements (f min-sum / g add).
// S1 registers operands and control, S2 registers results; valid/ready on both sides.
module llr_fg_pe_array #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_op,
    input  logic                        in_scale,
    input  logic [LANES-1:0]            in_mask,
    input  logic [LANES*DATA_WIDTH-1:0] in_a,
    input  logic [LANES*DATA_WIDTH-1:0] in_b,
    input  logic [LANES-1:0]            in_us,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_llr,
    output logic [CNT_WIDTH-1:0]        beat_cnt
);

    localparam int W = DATA_WIDTH;
    localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W:0]   SMAX = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0]   SMIN = -SMAX;

    // Negation/abs that never yields the asymmetric most-negative code
    function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] x);
        logic signed [W-1:0] r;
        if (x == MINV) r = MAXV;
        else           r = -x;
        return r;
    endfunction

    function automatic logic signed [W-1:0] abs_sat(input logic signed [W-1:0] x);
        logic signed [W-1:0] r;
        if (x[W-1]) r = neg_sat(x);
        else        r = x;
        return r;
    endfunction

    function automatic logic signed [W-1:0] pe(input logic op, input logic scale, input logic us,
                                              input logic signed [W-1:0] a,
                                              input logic signed [W-1:0] b);
        logic signed [W-1:0] ma, mb, m, an, r;
        logic signed [W:0]   s;
        ma = abs_sat(a);
        mb = abs_sat(b);
        m  = (ma < mb) ? ma : mb;
        an = us ? neg_sat(a) : a;
        s  = signed'({an[W-1], an}) + signed'({b[W-1], b});
        if (!op)              r = (a[W-1] == b[W-1]) ? m : -m;
        else if (scale)       r = s[W:1];
        else if (s > SMAX)    r = MAXV;
        else if (s < SMIN)    r = -MAXV;
        else                  r = s[W-1:0];
        return r;
    endfunction

    logic                  s1_valid, s1_op, s1_scale;
    logic [LANES-1:0]      s1_mask, s1_us;
    logic [LANES*W-1:0]    s1_a, s1_b;
    logic                  s2_valid;
    logic [LANES*W-1:0]    s2_llr;
    logic [LANES*W-1:0]    res;
    logic                  s1_adv, s2_adv;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;
    assign out_llr   = s2_llr;

    always_comb begin
        res = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (s1_mask[i])
                res[i*W +: W] = pe(s1_op, s1_scale, s1_us[i], s1_a[i*W +: W], s1_b[i*W +: W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= 1'b0;
            s1_scale <= 1'b0;
            s1_mask  <= '0;
            s1_us    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op    <= in_op;
                s1_scale <= in_scale;
                s1_mask  <= in_mask;
                s1_us    <= in_us;
                s1_a     <= in_a;
                s1_b     <= in_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_llr   <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid)
                s2_llr <= res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            beat_cnt <= '0;
        else if (s2_valid && out_ready)
            beat_cnt <= beat_cnt + 1'b1;
    end

endmodule

// File: tb/tb_llr_fg_pe_array.sv
// Directed self-checking bench for llr_fg_pe_array (W=8, LANES=4, 4-bit beat counter).
module tb_llr_fg_pe_array;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, in_op, in_scale;
    logic [L-1:0]   in_mask, in_us;
    logic [L*W-1:0] in_a, in_b;
    logic           out_valid, out_ready;
    logic [L*W-1:0] out_llr;
    logic [CW-1:0]  beat_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    llr_fg_pe_array #(.DATA_WIDTH(W), .LANES(L), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_scale(in_scale),
        .in_mask(in_mask), .in_a(in_a), .in_b(in_b), .in_us(in_us),
        .out_valid(out_valid), .out_ready(out_ready), .out_llr(out_llr), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic reset_pulse();
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Present one beat on an empty pipeline, wait for it, then consume it.
    task automatic run_beat(input logic op, input logic sc, input logic [L-1:0] mask,
                            input logic [L-1:0] us, input logic [L*W-1:0] a,
                            input logic [L*W-1:0] b, output logic [L*W-1:0] res,
                            output int lat);
        in_op = op; in_scale = sc; in_mask = mask; in_us = us; in_a = a; in_b = b;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_llr;
        @(posedge clk); #1;
    endtask

    localparam logic [31:0] T1_A = {8'h10, 8'h7F, 8'hF9, 8'h14};
    localparam logic [31:0] T1_B = {8'h10, 8'h7F, 8'h00, 8'h0A};
    localparam logic [31:0] T2_A = {8'h05, 8'h80, 8'h64, 8'h64};
    localparam logic [31:0] T2_B = {8'hFD, 8'h00, 8'h9C, 8'h64};
    localparam logic [31:0] T3_A = {8'h2D, 8'h00, 8'h80, 8'hE2};
    localparam logic [31:0] T3_B = {8'h3C, 8'hFB, 8'h80, 8'h0C};

    initial begin
        logic [31:0] res, prev, exp;
        logic [7:0]  pat;
        logic        stalled, fire_in, fire_out;
        int          lat, sent, recv, cyc;

        rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_scale = 1'b0;
        in_mask = '0; in_us = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_llr", out_llr, 32'd0);
        check("rst_beat_cnt", {28'd0, beat_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // g, halved sum; lane3 masked
        run_beat(1'b1, 1'b1, 4'b0111, 4'b0001, T1_A, T1_B, res, lat);
        check("g_scale_llr", res, 32'h007FFCFB);
        check("g_scale_latency", lat, 2);

        // g, saturated sum
        run_beat(1'b1, 1'b0, 4'b1111, 4'b0110, T2_A, T2_B, res, lat);
        check("g_sat_llr", res, 32'h027F817F);

        // f, in_scale must not matter
        run_beat(1'b0, 1'b0, 4'b1111, 4'b1010, T3_A, T3_B, res, lat);
        check("f_llr_sc0", res, 32'h2D007FF4);
        run_beat(1'b0, 1'b1, 4'b1111, 4'b1010, T3_A, T3_B, res, lat);
        check("f_llr_sc1", res, 32'h2D007FF4);
        run_beat(1'b0, 1'b1, 4'b1101, 4'b0000, T3_A, T3_B, res, lat);
        check("f_llr_mask", res, 32'h2D0000F4);
        check("cnt_after_5", {28'd0, beat_cnt}, 32'd5);

        // Backpressure stream: out_ready pattern 1,0,0,1,1,0,1,1 (bit i = cycle i)
        reset_pulse();
        pat = 8'b1101_1001;
        sent = 0; recv = 0; cyc = 0; stalled = 1'b0; prev = '0;
        while (recv < 8 && cyc < 200) begin
            out_ready = pat[cyc % 8];
            in_valid  = (sent < 8);
            in_op = 1'b1; in_scale = 1'b0; in_mask = '1; in_us = '0;
            in_b  = {4{8'd1}};
            in_a  = {8'(sent*4+3), 8'(sent*4+2), 8'(sent*4+1), 8'(sent*4)};
            #1;
            check("bp_in_ready", {31'd0, in_ready},
                  {31'd0, !((sent - recv) == 2 && !out_ready)});
            if (stalled) begin
                check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                check("bp_hold_llr", out_llr, prev);
            end
            if (out_valid) begin
                exp = {8'(recv*4+4), 8'(recv*4+3), 8'(recv*4+2), 8'(recv*4+1)};
                check("bp_data", out_llr, exp);
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            stalled  = out_valid && !out_ready;
            prev     = out_llr;
            // Garbage while stalled must never be captured
            if (!in_ready) in_a = 32'hDEADBEEF;
            @(posedge clk); #1;
            sent += int'(fire_in);
            recv += int'(fire_out);
            cyc++;
        end
        in_valid = 1'b0;
        check("bp_delivered", recv, 8);
        check("bp_beat_cnt", {28'd0, beat_cnt}, 32'd8);

        // Counter wrap: 17 beats into a 4-bit counter
        reset_pulse();
        out_ready = 1'b1; in_valid = 1'b1;
        repeat (17) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("cnt_wrap", {28'd0, beat_cnt}, 32'd1);

        // Fill both stages, then reset asynchronously
        out_ready = 1'b0;
        in_op = 1'b0; in_scale = 1'b0; in_mask = '1; in_us = '0; in_a = T3_A; in_b = T3_B;
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        check("full_out_llr", out_llr, 32'h2D007FF4);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_llr", out_llr, 32'd0);
        check("arst_beat_cnt", {28'd0, beat_cnt}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        run_beat(1'b1, 1'b1, 4'b0111, 4'b0001, T1_A, T1_B, res, lat);
        check("post_rst_llr", res, 32'h007FFCFB);
        check("post_rst_latency", lat, 2);
        check("post_rst_cnt", {28'd0, beat_cnt}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/llr_fg_pe_array.md
Name: llr_fg_pe_array

Overview:
- Parametrised, pipelined array of LANES LLR processing elements for the SC polar decoder datapath.
- Each lane computes either the f (min-sum) or the g (partial-sum-controlled add) LLR update on two's-complement LLRs.
- g supports two overflow policies per beat: scaled (sum halved, as in the existing g datapath) or saturated (full-scale clamp).
- Sits between the LLR memory read port and LLR write-back, with valid/ready handshakes on both sides so the decoder controller can stall either end.

Parameters:
- DATA_WIDTH, 8, LLR width in bits, two's complement; legal values 4..16.
- LANES, 4, number of parallel PEs per beat; legal values 1..64.
- CNT_WIDTH, 16, width of the processed-beat counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  array can accept a beat this cycle.
- in_op  in  1  0 = f, 1 = g; applies to all lanes of the beat.
- in_scale  in  1  g only: 1 = halve the sum, 0 = saturate the sum; ignored for f.
- in_mask  in  LANES  per-lane enable; a masked lane outputs 0.
- in_a  in  LANES*DATA_WIDTH  operand a per lane; lane i at bits [i*W +: W].
- in_b  in  LANES*DATA_WIDTH  operand b per lane, same packing.
- in_us  in  LANES  per-lane partial sum u_s, used by g.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_llr  out  LANES*DATA_WIDTH  per-lane result, same packing.
- beat_cnt  out  CNT_WIDTH  count of output beats accepted (out_valid && out_ready); wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset: all stage valids = 0, out_valid = 0, out_llr = 0, beat_cnt = 0. in_ready = 1 one cycle after reset deasserts.
- Reset mid-operation: any in-flight beats are discarded and are not counted.
- Pipeline:
  - Stage S1 registers the operands and control.
  - Stage S2 registers the computed results and drives out_llr / out_valid.
  - Latency from input acceptance to out_valid is 2 cycles with no stall.
  - Throughput is 1 beat per cycle.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
  - A beat is accepted when in_valid && in_ready.
- While out_valid && !out_ready, out_llr and out_valid hold stable. No bubble is inserted on release.
- Simultaneous accept and emit in the same cycle is legal and must be lossless.
- Define W = DATA_WIDTH, MAX = 2^(W-1)-1, and sat(x) = clamp(x, -MAX, +MAX). Results are symmetric: -2^(W-1) is never produced.
- f (in_op = 0):
  - |x| = sat(abs(x)), so -2^(W-1) maps to MAX.
  - m = min(|a|, |b|).
  - Result = m if sign(a) == sign(b), else -m.
  - Zero operands are treated as positive.
- g (in_op = 1):
  - a' = us ? -a : a, where -(-2^(W-1)) = MAX.
  - s = a' + b, computed exactly in W+1 bits.
  - If in_scale = 1: result = s >>> 1 (arithmetic shift, rounds toward -inf), truncated to W bits. This always fits.
  - If in_scale = 0: result = sat(s).
- Masked lane (in_mask[i] = 0): result = 0, regardless of op.
- beat_cnt:
  - Increments by 1 on each accepted output beat.
  - All-ones wraps to 0.
  - Not affected by masking.
- Inputs are sampled only on acceptance. Changes on the input ports while in_ready = 0 have no effect.

Test Plan:
- W=8, LANES=4, g, scale=1: lane0 a=20, b=10, us=1 -> out=-5; lane1 a=-7, b=0, us=0 -> -4; lane2 a=127, b=127, us=0 -> 127; lane3 masked -> 0. out_valid asserted exactly 2 cycles after acceptance.
- g, scale=0 saturation: a=100, b=100, us=0 -> 127; a=100, b=-100, us=1 -> -127; a=-128, b=0, us=1 -> 127; a=5, b=-3, us=0 -> 2.
- f: a=-30, b=12 -> -12; a=-128, b=-128 -> 127; a=0, b=-5 -> 0; a=45, b=60 -> 45; in_scale toggled has no effect on f results.
- Backpressure: stream 8 beats with in_valid held high and out_ready pattern 1,0,0,1,1,0,1,1,... -> all 8 results delivered in order, none duplicated or dropped; out_llr stable during stalls; in_ready low only when both stages are full and out_ready = 0; beat_cnt = 8 at end.
- Counter wrap: CNT_WIDTH=4, accept 17 beats -> beat_cnt = 1.
- Reset mid-stream: assert rst with both stages full -> out_valid = 0 and out_llr = 0 immediately (asynchronous); beat_cnt = 0; after release, a new beat emerges 2 cycles after acceptance with the correct value and no stale data.
